// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared definitions for the multiplier scheduler.
//   - N_DEF   : default operand width (product is 2*N_DEF bits)
//   - tmo_of  : watchdog limit derived from the operand width (4*N+8)
//   - state_t : scheduler FSM encoding (IDLE=0, START=1, WAIT=2, RESP=3)
package mult_sched_pkg;

    localparam int N_DEF = 8;

    // A shift-add multiplier needs about N cycles; 4*N+8 leaves ample slack
    // before the watchdog declares the multiplier hung.
    function automatic int tmo_of(input int n);
        return 4 * n + 8;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: 2-way round-robin grant decision (purely combinational).
// Ports:
//   req0, req1  in  : pending requests
//   last        in  : index of the requester served most recently
//   gnt_valid   out : at least one request is pending
//   sel         out : granted index; on contention the one that is not last
module rr_arbiter (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic sel
);

    assign gnt_valid = req0 | req1;
    // With a single requester, sel simply follows req1.
    assign sel = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: places one shared shift-add multiplier between two
// requesters. Grants round-robin, latches the winner's operands, pulses the
// multiplier start, waits for done under a watchdog and returns the product
// with a one-cycle acknowledge.
//
// Request/acknowledge handshake: a requester raises reqX with aX/bX stable and
// keeps both unchanged until ackX pulses for one cycle. At the edge closing
// that ack cycle it either drops reqX or keeps it high to ask again. p and err
// are meaningful only while ackX is high. Requests are looked at only in IDLE.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req0/req1         : requests
//   a0,b0 / a1,b1     : operands of requester 0 / 1 (N bits)
//   ack0/ack1         : one-cycle completion pulses (registered)
//   p                 : product (2N bits), 0 on watchdog abort (registered)
//   err               : watchdog expired, high together with ack (registered)
//   busy              : scheduler is not in IDLE
//   ma, mb            : operands driven to the multiplier (registered)
//   mst               : multiplier start pulse (from state and midle)
//   midle, mdone, mp  : multiplier idle, done pulse and product
//   dbg_state         : current FSM state
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int TMO = tmo_of(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0,
    input  logic           req1,
    input  logic [N-1:0]   a0,
    input  logic [N-1:0]   b0,
    input  logic [N-1:0]   a1,
    input  logic [N-1:0]   b1,
    output logic           ack0,
    output logic           ack1,
    output logic [2*N-1:0] p,
    output logic           err,
    output logic           busy,
    output logic [N-1:0]   ma,
    output logic [N-1:0]   mb,
    output logic           mst,
    input  logic           midle,
    input  logic           mdone,
    input  logic [2*N-1:0] mp,
    output logic [1:0]     dbg_state
);

    localparam int CW = $clog2(TMO + 1);
    // Counter value seen during the TMO-th cycle spent in WAIT.
    localparam logic [CW-1:0] WD_LAST = CW'(TMO - 1);

    state_t         state, state_nx;
    logic           sel, sel_nx;
    logic           last, last_nx;
    logic [N-1:0]   ma_nx, mb_nx;
    logic [2*N-1:0] p_nx;
    logic           err_nx, ack0_nx, ack1_nx;
    logic [CW-1:0]  wd, wd_nx;
    logic           gnt_valid, gnt_sel;

    rr_arbiter u_arb (
        .req0      (req0),
        .req1      (req1),
        .last      (last),
        .gnt_valid (gnt_valid),
        .sel       (gnt_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sel   <= 1'b0;
            last  <= 1'b1;      // requester 0 wins the first contended grant
            ma    <= '0;
            mb    <= '0;
            p     <= '0;
            err   <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            wd    <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            last  <= last_nx;
            ma    <= ma_nx;
            mb    <= mb_nx;
            p     <= p_nx;
            err   <= err_nx;
            ack0  <= ack0_nx;
            ack1  <= ack1_nx;
            wd    <= wd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        last_nx  = last;
        ma_nx    = ma;
        mb_nx    = mb;
        p_nx     = '0;
        err_nx   = 1'b0;
        ack0_nx  = 1'b0;
        ack1_nx  = 1'b0;
        wd_nx    = wd;
        unique case (state)
            S_IDLE: begin
                if (gnt_valid) begin
                    sel_nx   = gnt_sel;
                    ma_nx    = gnt_sel ? a1 : a0;
                    mb_nx    = gnt_sel ? b1 : b0;
                    state_nx = S_START;
                end
            end
            S_START: begin
                wd_nx = '0;
                if (midle) state_nx = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the expiry cycle still counts as success.
                if (mdone) begin
                    p_nx     = mp;
                    ack0_nx  = ~sel;
                    ack1_nx  = sel;
                    state_nx = S_RESP;
                end else if (wd == WD_LAST) begin
                    err_nx   = 1'b1;
                    ack0_nx  = ~sel;
                    ack1_nx  = sel;
                    state_nx = S_RESP;
                end else begin
                    wd_nx = wd + 1'b1;
                end
            end
            S_RESP: begin
                last_nx  = sel;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // The start pulse lasts exactly the cycle that moves START into WAIT.
    assign mst       = (state == S_START) && midle;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: bench for mult_scheduler with a cycle-level multiplier
// model, requester drivers and a transaction-level reference model.
module tb_mult_scheduler;

    localparam int N   = 8;
    localparam int TMO = 4 * N + 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic           req0, req1, ack0, ack1, err, busy, mst, midle, mdone;
    logic [N-1:0]   a0, b0, a1, b1, ma, mb;
    logic [2*N-1:0] p, mp;
    logic [1:0]     dbg_state;

    mult_scheduler #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .p(p), .err(err), .busy(busy),
        .ma(ma), .mb(mb), .mst(mst),
        .midle(midle), .mdone(mdone), .mp(mp),
        .dbg_state(dbg_state)
    );

    // ---------------- bench state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mst_cnt = 0, mst_bad = 0, mst_cyc = 0;

    // scoreboard entries: {ack1,ack0, err, p, latency from MSt to Ack}
    localparam int W = 2 + 1 + 2 * N + 8;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];

    // requester side
    logic [N-1:0] op_a0[$], op_b0[$], op_a1[$], op_b1[$];
    int pend0 = 0, pend1 = 0;
    bit ack0_seen = 0, ack1_seen = 0;
    logic last_m = 1'b1;

    // multiplier model
    int m_lat = 4;
    bit m_never = 0, m_run = 0, stray = 0;
    int m_cnt = 0, hold = 0;
    logic [N-1:0] m_a, m_b;

    // ---------------- driver / model / monitor ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (ack0_seen && pend0 > 0) begin
            void'(op_a0.pop_front()); void'(op_b0.pop_front()); pend0--;
        end
        if (ack1_seen && pend1 > 0) begin
            void'(op_a1.pop_front()); void'(op_b1.pop_front()); pend1--;
        end
        ack0_seen = 0;
        ack1_seen = 0;
        req0 = (pend0 > 0);
        req1 = (pend1 > 0);
        if (pend0 > 0) begin a0 = op_a0[0]; b0 = op_b0[0]; end
        if (pend1 > 0) begin a1 = op_a1[0]; b1 = op_b1[0]; end

        mdone = 1'b0;
        mp    = '0;
        if (m_run && !m_never) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_run = 0;
                mdone = 1'b1;
                mp    = {8'd0, m_a} * {8'd0, m_b};
            end
        end
        if (stray) begin
            mdone = 1'b1;
            mp    = 16'hdead;
            stray = 0;
        end
        if (hold > 0) begin
            midle = 1'b0;
            hold--;
        end else begin
            midle = !m_run;
        end

        @(negedge clk);
        cyc++;
        if (mst) begin
            mst_cnt++;
            if (!midle) mst_bad++;
            m_run   = 1;
            m_cnt   = m_lat;
            m_a     = ma;
            m_b     = mb;
            mst_cyc = cyc;
        end
        if (ack0 || ack1) begin
            obs_q.push_back({ack1, ack0, err, p, 8'(cyc - mst_cyc)});
            ack0_seen = ack0;
            ack1_seen = ack1;
        end
    endtask

    // Reference model: serves the pending transactions in round-robin order.
    task automatic model_build();
        int k0 = 0, k1 = 0, c0 = pend0, c1 = pend1;
        logic who;
        logic [N-1:0] a, b;
        logic [2*N-1:0] prod;
        while (c0 > 0 || c1 > 0) begin
            if (c0 > 0 && c1 > 0) who = ~last_m;
            else who = (c1 > 0);
            if (!who) begin a = op_a0[k0]; b = op_b0[k0]; k0++; c0--; end
            else begin a = op_a1[k1]; b = op_b1[k1]; k1++; c1--; end
            prod = m_never ? '0 : ({8'd0, a} * {8'd0, b});
            exp_q.push_back({who ? 2'b10 : 2'b01, m_never, prod,
                             8'(m_never ? TMO + 1 : m_lat + 1)});
            last_m = who;
        end
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while ((pend0 > 0 || pend1 > 0) && n < budget) begin
            step();
            n++;
        end
        step();
        if (pend0 > 0 || pend1 > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: pending %0d/%0d after %0d cycles, required 0/0", pend0, pend1, budget);
            pend0 = 0; pend1 = 0;
            op_a0.delete(); op_b0.delete(); op_a1.delete(); op_b1.delete();
        end
    endtask

    task automatic push_op(input bit who, input logic [N-1:0] a, input logic [N-1:0] b);
        if (!who) begin op_a0.push_back(a); op_b0.push_back(b); end
        else begin op_a1.push_back(a); op_b1.push_back(b); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; midle = 1'b1; mdone = 1'b1;
        a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        mp = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ack0, ack1, err, busy, mst, dbg_state} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ack0,ack1,err,busy,mst,state=%b required 0", {ack0, ack1, err, busy, mst, dbg_state});
        end
        n_cmp++;
        if ({p, ma, mb} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got p=%h ma=%h mb=%h required 0", p, ma, mb);
        end
        req0 = 1'b0; req1 = 1'b0; mdone = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        last_m = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b state=%0d required busy=0 state=0", busy, dbg_state);
        end
    endtask

    task automatic test_contention();
        logic [W-1:0] o, e;
        int base = mst_cnt;
        m_lat = $urandom_range(1, 6);
        for (int i = 0; i < 2; i++) begin
            push_op(0, 8'($urandom), 8'($urandom));
            push_op(1, 8'd7, 8'd9);
        end
        pend0 = 2; pend1 = 2;
        model_build();
        run_until_done(200);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL contention count: got %0d acks required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            o = obs_q[i]; e = exp_q[i]; n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL contention txn %0d: got {ack,err,p,lat}=%h required %h", i, o, e); end
        end
        n_cmp++;
        if (mst_cnt - base != 4) begin n_fail++; $display("FAIL contention mst: got %0d pulses required 4", mst_cnt - base); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_single();
        logic [W-1:0] o, e;
        int base = mst_cnt;
        int t0;
        m_lat = 17;
        push_op(0, 8'd13, 8'd11);
        pend0 = 1;
        model_build();
        t0 = cyc;
        run_until_done(100);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL single count: got %0d acks required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            o = obs_q[i]; e = exp_q[i]; n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL single txn %0d: got {ack,err,p,lat}=%h required %h", i, o, e); end
        end
        n_cmp++;
        if (mst_cnt - base != 1 || mst_cyc != t0 + 2) begin
            n_fail++;
            $display("FAIL single mst: got %0d pulses at cycle +%0d required 1 at +2", mst_cnt - base, mst_cyc - t0);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_midle_busy();
        logic [W-1:0] o, e;
        int base = mst_cnt;
        int t0;
        m_lat = 5;
        push_op(0, 8'($urandom), 8'($urandom));
        pend0 = 1;
        model_build();
        hold = 6;           // low in the request cycle and the 5 cycles after the grant
        t0 = cyc;
        step();
        stray = 1;          // lands in START, must be ignored
        run_until_done(100);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL midle count: got %0d acks required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            o = obs_q[i]; e = exp_q[i]; n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL midle txn %0d: got {ack,err,p,lat}=%h required %h", i, o, e); end
        end
        n_cmp++;
        if (mst_cnt - base != 1 || mst_cyc != t0 + 7 || mst_bad != 0) begin
            n_fail++;
            $display("FAIL midle mst: got %0d pulses at +%0d (%0d while busy) required 1 at +7 (0)", mst_cnt - base, mst_cyc - t0, mst_bad);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_watchdog();
        logic [W-1:0] o, e;
        // Multiplier never answers.
        m_never = 1;
        push_op(1, 8'($urandom), 8'($urandom));
        pend1 = 1;
        model_build();
        run_until_done(200);
        m_never = 0;
        m_run   = 0;
        step();
        // Done arrives exactly on the expiry cycle.
        m_lat = TMO;
        push_op(0, 8'($urandom), 8'($urandom));
        pend0 = 1;
        model_build();
        run_until_done(200);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL watchdog count: got %0d acks required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            o = obs_q[i]; e = exp_q[i]; n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL watchdog txn %0d: got {ack,err,p,lat}=%h required %h", i, o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_wait();
        logic [W-1:0] o, e;
        int base = mst_cnt;
        int n = 0;
        m_lat = 20;
        push_op(1, 8'($urandom), 8'($urandom));
        pend1 = 1;
        while (mst_cnt == base && n < 20) begin step(); n++; end
        repeat (3) step();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        pend0 = 0; pend1 = 0; ack0_seen = 0; ack1_seen = 0;
        op_a0.delete(); op_b0.delete(); op_a1.delete(); op_b1.delete();
        #1;
        n_cmp++;
        if ({ack0, ack1, err, busy, mst, dbg_state} !== 7'd0) begin
            n_fail++;
            $display("FAIL midwait_ctrl: got ack0,ack1,err,busy,mst,state=%b required 0", {ack0, ack1, err, busy, mst, dbg_state});
        end
        n_cmp++;
        if ({p, ma, mb} !== 32'd0) begin
            n_fail++;
            $display("FAIL midwait_data: got p=%h ma=%h mb=%h required 0", p, ma, mb);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        last_m = 1'b1;
        repeat (30) step();    // the aborted multiply finishes while idle
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL midwait_noack: got %0d acks after reset required 0", obs_q.size());
        end
        obs_q.delete();
        m_lat = $urandom_range(1, 8);
        push_op(0, 8'($urandom), 8'($urandom));
        push_op(1, 8'($urandom), 8'($urandom));
        pend0 = 1; pend1 = 1;
        model_build();
        run_until_done(200);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL midwait count: got %0d acks required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            o = obs_q[i]; e = exp_q[i]; n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL midwait txn %0d: got {ack,err,p,lat}=%h required %h", i, o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_stray_idle();
        stray = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (busy !== 1'b0 || dbg_state !== 2'd0) begin
                n_fail++;
                $display("FAIL stray_idle cycle %0d: got busy=%b state=%0d required 0/0", i, busy, dbg_state);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL stray_idle ack: got %0d acks required 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_random();
        logic [W-1:0] o, e;
        int base, ntx;
        for (int r = 0; r < 6; r++) begin
            base  = mst_cnt;
            pend0 = $urandom_range(0, 3);
            pend1 = $urandom_range(0, 3);
            if (pend0 == 0 && pend1 == 0) pend0 = 1;
            for (int i = 0; i < pend0; i++) push_op(0, 8'($urandom), 8'($urandom));
            for (int i = 0; i < pend1; i++) push_op(1, 8'($urandom), 8'($urandom));
            ntx   = pend0 + pend1;
            m_lat = $urandom_range(1, 12);
            hold  = $urandom_range(0, 3);
            model_build();
            run_until_done(400);
            n_cmp++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL random%0d count: got %0d acks required %0d", r, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                o = obs_q[i]; e = exp_q[i]; n_cmp++;
                if (o !== e) begin n_fail++; $display("FAIL random%0d txn %0d: got {ack,err,p,lat}=%h required %h", r, i, o, e); end
            end
            n_cmp++;
            if (mst_cnt - base != ntx || mst_bad != 0) begin
                n_fail++;
                $display("FAIL random%0d mst: got %0d pulses (%0d while busy) required %0d (0)", r, mst_cnt - base, mst_bad, ntx);
            end
            obs_q.delete(); exp_q.delete();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; midle = 1'b1; mdone = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; mp = '0;
        test_reset();
        test_contention();
        test_single();
        test_midle_busy();
        test_watchdog();
        test_reset_mid_wait();
        test_stray_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
